lock_code_tx: RTL and testbench
===============================

LOCK_CODE_TX -- requirements
Module: lock_code_tx

Interface
REQ-001 The module SHALL provide parameter CODE_W, default 8, giving the maximum code length in bits.
REQ-002 The module SHALL provide parameter TIMEOUT, default 4, giving the number of cycles to wait for unlock after the last bit.
REQ-003 The module SHALL provide parameter MAX_RETRY, default 2, giving the number of retransmissions after the first attempt.
REQ-004 The module SHALL provide parameter GAP, default 2, giving the number of idle cycles between attempts.
REQ-005 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request to send; sampled only in IDLE.
REQ-008 code  input  CODE_W  code bits; the first bit sent is code[len-1] and the last is code[0].
REQ-009 len  input  $clog2(CODE_W+1)  number of bits to send; legal range 1..CODE_W.
REQ-010 unlock  input  1  response from the lock receiver.
REQ-011 d  output  1  serial code bit driven to the lock receiver.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when the transaction ends.
REQ-014 success  output  1  sticky; unlock was seen in WAIT.
REQ-015 fail  output  1  sticky; all attempts timed out.
REQ-016 reject  output  1  one-cycle pulse; start was refused because len was illegal.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, SEND, WAIT, GAP, DONE.
REQ-018 In IDLE, start=1 with a legal len SHALL:
- capture code and len into internal registers;
- clear success and fail;
- clear the retry counter;
- move to SEND on the next edge.
REQ-019 In IDLE, start=1 with len=0 or len>CODE_W SHALL pulse reject for one cycle, the cycle after start, and remain in IDLE.
REQ-020 In SEND, d SHALL present exactly one captured bit per cycle, MSB-first from bit len-1 down to bit 0, for exactly len cycles; then the FSM SHALL enter WAIT.
REQ-021 d SHALL be 0 in every state other than SEND.
REQ-022 In WAIT, the module SHALL count cycles from 1 to TIMEOUT.
- unlock=1 on any WAIT cycle: set success and go to DONE.
- TIMEOUT cycles elapse with no unlock: go to GAP if the retry count is below MAX_RETRY, otherwise set fail and go to DONE.
REQ-023 GAP SHALL last exactly GAP cycles, increment the retry counter on entry, and then re-enter SEND using the same captured code and len.
REQ-024 unlock SHALL be ignored in SEND, GAP, DONE and IDLE.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-026 start SHALL be ignored whenever busy=1.
- Captured code and len SHALL NOT change during a transaction.
REQ-027 An unlock arriving on the same cycle as the last TIMEOUT cycle SHALL count as success.
REQ-028 success and fail SHALL never both be 1, and SHALL hold their values until the next accepted start or reset.
REQ-029 All counters SHALL be sized to hold their maximum parameter value without wrap-around.

Reset
REQ-030 reset=1 at a clock edge SHALL force the following on the next cycle, from any state including mid-SEND:
- state = IDLE;
- d, busy, done, success, fail and reject = 0;
- shift register and all counters = 0.
REQ-031 An accepted start is the only event that SHALL leave IDLE; reset alone SHALL NOT.

Verification
REQ-032 Basic send: code=8'b0000_0111, len=3, start pulse → busy rises next cycle; d=1,1,1 on three consecutive cycles; unlock=1 on the second WAIT cycle → done pulse, success=1, fail=0.
REQ-033 Retry exhaustion: len=2, code=2'b11, unlock held 0 → three SEND bursts (1 + MAX_RETRY), each separated by 2 d=0 GAP cycles → then done and fail=1; total busy cycles = 3*(2+4) + 2*2 + 1 = 23.
REQ-034 Illegal length: start with len=0, then start with len=9 → reject pulses once for each, busy stays 0, d stays 0.
REQ-035 Busy start and late unlock:
- start re-asserted during SEND with a different code → ignored, original bits are sent;
- unlock asserted during SEND → no effect;
- unlock on WAIT cycle 4 → success.
REQ-036 Reset mid-operation: reset asserted on the 2nd SEND cycle of an 8-bit code → next cycle all outputs 0 and state IDLE; a fresh start then sends the full 8 bits from bit 7.

Source files
------------

// File: rtl/lock_code_tx_if.sv
// Handshake bundle between a lock-code requester and the lock_code_tx serialiser.
// The master drives the request and unlock response; the slave is the transmitter.
interface lock_code_tx_if #(
   parameter int CODE_W = 8
);
   localparam int LEN_W = $clog2(CODE_W + 1);

   logic              start;
   logic [CODE_W-1:0] code;
   logic [LEN_W-1:0]  len;
   logic              unlock;
   logic              d;
   logic              busy;
   logic              done;
   logic              success;
   logic              fail;
   logic              reject;

   modport master (
      output start, code, len, unlock,
      input  d, busy, done, success, fail, reject
   );

   modport slave (
      input  start, code, len, unlock,
      output d, busy, done, success, fail, reject
   );
endinterface

// File: rtl/lock_code_tx.sv
// Serial lock-code transmitter: sends a captured code MSB-first, waits for unlock,
// and retries after an idle gap until success or the retry budget is spent.
module lock_code_tx #(
   parameter int CODE_W    = 8,
   parameter int TIMEOUT   = 4,
   parameter int MAX_RETRY = 2,
   parameter int GAP       = 2
) (
   input  logic           clk,
   input  logic           reset,
   lock_code_tx_if.slave  bus
);
   localparam int LEN_W  = $clog2(CODE_W + 1);
   localparam int WAIT_W = (TIMEOUT > 0)   ? $clog2(TIMEOUT + 1)   : 1;
   localparam int GAP_W  = (GAP > 0)       ? $clog2(GAP + 1)       : 1;
   localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SEND = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_GAP  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]        state_q,    state_d;
   logic [CODE_W-1:0] code_q,     code_d;
   logic [LEN_W-1:0]  len_q,      len_d;
   logic [CODE_W-1:0] sh_q,       sh_d;
   logic [LEN_W-1:0]  bit_cnt_q,  bit_cnt_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q,  gap_cnt_d;
   logic [RTY_W-1:0]  retry_q,    retry_d;
   logic              success_q,  success_d;
   logic              fail_q,     fail_d;
   logic              reject_q,   reject_d;

   function automatic logic len_ok(input logic [LEN_W-1:0] l);
      return (l != '0) && (l <= LEN_W'(CODE_W));
   endfunction

   // Left-justify the code so bit len-1 sits at the shift register MSB.
   function automatic logic [CODE_W-1:0] align(input logic [CODE_W-1:0] c,
                                               input logic [LEN_W-1:0]  l);
      return c << (LEN_W'(CODE_W) - l);
   endfunction

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      len_d      = len_q;
      sh_d       = sh_q;
      bit_cnt_d  = bit_cnt_q;
      wait_cnt_d = wait_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      retry_d    = retry_q;
      success_d  = success_q;
      fail_d     = fail_q;
      reject_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (len_ok(bus.len)) begin
                  code_d    = bus.code;
                  len_d     = bus.len;
                  sh_d      = align(bus.code, bus.len);
                  bit_cnt_d = bus.len;
                  retry_d   = '0;
                  success_d = 1'b0;
                  fail_d    = 1'b0;
                  state_d   = S_SEND;
               end else begin
                  reject_d = 1'b1;
               end
            end
         end

         S_SEND: begin
            sh_d = sh_q << 1;
            if (bit_cnt_q == LEN_W'(1)) begin
               bit_cnt_d  = '0;
               wait_cnt_d = WAIT_W'(1);
               state_d    = S_WAIT;
            end else begin
               bit_cnt_d = bit_cnt_q - LEN_W'(1);
            end
         end

         // Unlock wins even on the final timeout cycle.
         S_WAIT: begin
            if (bus.unlock) begin
               success_d  = 1'b1;
               wait_cnt_d = '0;
               state_d    = S_DONE;
            end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
               wait_cnt_d = '0;
               if (retry_q < RTY_W'(MAX_RETRY)) begin
                  retry_d   = retry_q + RTY_W'(1);
                  gap_cnt_d = GAP_W'(1);
                  state_d   = S_GAP;
               end else begin
                  fail_d  = 1'b1;
                  state_d = S_DONE;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end

         S_GAP: begin
            if (gap_cnt_q >= GAP_W'(GAP)) begin
               gap_cnt_d = '0;
               sh_d      = align(code_q, len_q);
               bit_cnt_d = len_q;
               state_d   = S_SEND;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end

         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         code_q     <= '0;
         len_q      <= '0;
         sh_q       <= '0;
         bit_cnt_q  <= '0;
         wait_cnt_q <= '0;
         gap_cnt_q  <= '0;
         retry_q    <= '0;
         success_q  <= 1'b0;
         fail_q     <= 1'b0;
         reject_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         len_q      <= len_d;
         sh_q       <= sh_d;
         bit_cnt_q  <= bit_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         retry_q    <= retry_d;
         success_q  <= success_d;
         fail_q     <= fail_d;
         reject_q   <= reject_d;
      end
   end

   assign bus.d       = (state_q == S_SEND) & sh_q[CODE_W-1];
   assign bus.busy    = (state_q != S_IDLE);
   assign bus.done    = (state_q == S_DONE);
   assign bus.success = success_q;
   assign bus.fail    = fail_q;
   assign bus.reject  = reject_q;
endmodule

// File: tb/tb_lock_code_tx.sv
// Directed bench for lock_code_tx: inputs change and outputs are sampled on the
// falling edge, so every check sees the state produced by the preceding rising edge.
module tb_lock_code_tx;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   busy_cnt;
   logic exp_d;
   logic [7:0] code_v;

   always #5 clk = ~clk;

   lock_code_tx_if #(.CODE_W(8)) bus ();

   lock_code_tx #(
      .CODE_W(8), .TIMEOUT(4), .MAX_RETRY(2), .GAP(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.code   = 8'h00;
      bus.len    = 4'd0;
      bus.unlock = 1'b0;
      @(negedge clk);
      step();
      step();
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_d", bus.d, 1'b0);
      chk1("rst_done", bus.done, 1'b0);
      chk1("rst_success", bus.success, 1'b0);
      chk1("rst_fail", bus.fail, 1'b0);
      chk1("rst_reject", bus.reject, 1'b0);
      reset = 1'b0;
      step();
      chk1("idle_stays", bus.busy, 1'b0);

      // Basic send: three ones, unlock on second WAIT cycle.
      bus.code  = 8'b0000_0111;
      bus.len   = 4'd3;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk1("b_busy", bus.busy, 1'b1);
      chk1("b_d0", bus.d, 1'b1);
      step();
      chk1("b_d1", bus.d, 1'b1);
      step();
      chk1("b_d2", bus.d, 1'b1);
      step();
      chk1("b_wait1_d", bus.d, 1'b0);
      chk1("b_wait1_busy", bus.busy, 1'b1);
      step();
      chk1("b_wait2_done", bus.done, 1'b0);
      bus.unlock = 1'b1;
      step();
      bus.unlock = 1'b0;
      chk1("b_done", bus.done, 1'b1);
      chk1("b_success", bus.success, 1'b1);
      chk1("b_fail", bus.fail, 1'b0);
      step();
      chk1("b_done_pulse", bus.done, 1'b0);
      chk1("b_idle", bus.busy, 1'b0);
      chk1("b_success_hold", bus.success, 1'b1);

      // Retry exhaustion: 3 attempts of 2 bits, no unlock.
      bus.code  = 8'b0000_0011;
      bus.len   = 4'd2;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      busy_cnt = 0;
      for (int p = 0; p < 23; p++) begin
         exp_d = (p < 22) && ((p % 8) < 2);
         if (bus.busy) busy_cnt++;
         chk1($sformatf("r_d_%0d", p), bus.d, exp_d);
         chk1($sformatf("r_done_%0d", p), bus.done, (p == 22));
         if (p == 22) begin
            chk1("r_fail", bus.fail, 1'b1);
            chk1("r_success", bus.success, 1'b0);
         end
         step();
      end
      chk1("r_idle", bus.busy, 1'b0);
      chkn("r_busy_cycles", busy_cnt, 23);
      chk1("r_fail_hold", bus.fail, 1'b1);

      // Illegal lengths 0 and 9.
      bus.len   = 4'd0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk1("i0_reject", bus.reject, 1'b1);
      chk1("i0_busy", bus.busy, 1'b0);
      chk1("i0_d", bus.d, 1'b0);
      step();
      chk1("i0_reject_pulse", bus.reject, 1'b0);
      bus.len   = 4'd9;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk1("i9_reject", bus.reject, 1'b1);
      chk1("i9_busy", bus.busy, 1'b0);
      chk1("i9_d", bus.d, 1'b0);
      chk1("i9_fail_kept", bus.fail, 1'b1);
      step();
      chk1("i9_reject_pulse", bus.reject, 1'b0);
      chk1("i9_busy2", bus.busy, 1'b0);

      // Busy start ignored, unlock in SEND ignored, unlock on WAIT cycle 4.
      bus.code  = 8'h16;
      bus.len   = 4'd5;
      bus.start = 1'b1;
      step();
      chk1("s_d0", bus.d, 1'b1);
      chk1("s_fail_cleared", bus.fail, 1'b0);
      bus.code   = 8'hFF;
      bus.len    = 4'd8;
      bus.unlock = 1'b1;
      step();
      chk1("s_d1", bus.d, 1'b0);
      step();
      chk1("s_d2", bus.d, 1'b1);
      step();
      chk1("s_d3", bus.d, 1'b1);
      step();
      chk1("s_d4", bus.d, 1'b0);
      chk1("s_no_success", bus.success, 1'b0);
      bus.start  = 1'b0;
      bus.unlock = 1'b0;
      step();
      chk1("s_wait1_busy", bus.busy, 1'b1);
      chk1("s_wait1_d", bus.d, 1'b0);
      step();
      step();
      step();
      chk1("s_wait4_done", bus.done, 1'b0);
      bus.unlock = 1'b1;
      step();
      bus.unlock = 1'b0;
      chk1("s_done", bus.done, 1'b1);
      chk1("s_success", bus.success, 1'b1);
      chk1("s_fail", bus.fail, 1'b0);
      step();
      chk1("s_idle", bus.busy, 1'b0);

      // Reset on the 2nd SEND cycle of an 8-bit code, then a clean resend.
      bus.code  = 8'hA5;
      bus.len   = 4'd8;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk1("m_d7", bus.d, 1'b1);
      step();
      chk1("m_d6", bus.d, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk1("m_busy", bus.busy, 1'b0);
      chk1("m_d", bus.d, 1'b0);
      chk1("m_done", bus.done, 1'b0);
      chk1("m_success", bus.success, 1'b0);
      chk1("m_fail", bus.fail, 1'b0);
      chk1("m_reject", bus.reject, 1'b0);
      step();
      chk1("m_stay_idle", bus.busy, 1'b0);
      code_v    = 8'hA5;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk1($sformatf("m_bit%0d", 7 - i), bus.d, code_v[7-i]);
         step();
      end
      chk1("m_wait_d", bus.d, 1'b0);
      chk1("m_wait_busy", bus.busy, 1'b1);
      bus.unlock = 1'b1;
      step();
      bus.unlock = 1'b0;
      chk1("m_final_done", bus.done, 1'b1);
      chk1("m_final_success", bus.success, 1'b1);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
